gessm_dot_accumulator: RTL and testbench

//  Downstream consumer of the gESSM approximate unsigned multipliers (e.g. n16/m8/q5, 32-bit product).

---
 rtl/gessm_pkg.sv | 11 +
 rtl/gessm_dot_accumulator_sat_add.sv | 26 ++
 rtl/gessm_dot_accumulator.sv | 119 +++++++++++
 tb/tb_gessm_dot_accumulator.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gessm_pkg.sv
// Shared definitions for the gESSM product-accumulation datapath.
package gessm_pkg;

  localparam int unsigned GESSM_PW = 32;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } gessm_acc_state_t;

endpackage

// File: rtl/gessm_dot_accumulator_sat_add.sv
// Unsigned saturating adder: sum = min(a + zext(b), 2^AW-1); ovf flags the clamp.
module gessm_sat_add #(
  parameter int unsigned AW = 40,
  parameter int unsigned PW = 32
) (
  input  logic [AW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          ovf
);

  generate
    if (AW < PW) begin : g_bad_width
      $error("gessm_sat_add: AW must be >= PW");
    end
  endgenerate

  logic [AW:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, a} + {{(AW + 1 - PW){1'b0}}, b};
    ovf      = wide_sum[AW];
    sum      = ovf ? '1 : wide_sum[AW-1:0];
  end

endmodule

// File: rtl/gessm_dot_accumulator.sv
// Accumulates gESSM products into one saturated dot-product sum per vector,
// delivered through a valid/ready result port.
module gessm_dot_accumulator
  import gessm_pkg::*;
#(
  parameter int unsigned PW  = GESSM_PW,
  parameter int unsigned AW  = 40,
  parameter int unsigned LEN = 16,
  localparam int unsigned CW = $clog2(LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  generate
    if (AW < PW) begin : g_bad_aw
      $error("gessm_dot_accumulator: AW must be >= PW");
    end
    if (LEN < 1) begin : g_bad_len
      $error("gessm_dot_accumulator: LEN must be >= 1");
    end
  endgenerate

  gessm_acc_state_t state_q, state_d;

  logic [AW-1:0] acc_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic [AW-1:0] sum_next;
  logic          carry;
  logic [CW-1:0] count_inc;
  logic          beat;
  logic          term_beat;

  gessm_sat_add #(
    .AW (AW),
    .PW (PW)
  ) u_sat_add (
    .a   (acc_q),
    .b   (in_prod),
    .sum (sum_next),
    .ovf (carry)
  );

  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
    beat      = in_valid && in_ready;
    count_inc = count_q + CW'(1);
    // in_last and a full vector coincide into one termination
    term_beat = beat && (in_last || (count_inc == CW'(LEN)));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (term_beat) state_d = DONE;
      DONE:    if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (beat) begin
            acc_q   <= sum_next;
            count_q <= count_inc;
            ovf_q   <= ovf_q | carry;
          end
          if (term_beat) begin
            out_sum   <= sum_next;
            out_count <= count_inc;
            out_ovf   <= ovf_q | carry;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: begin
          acc_q   <= '0;
          count_q <= '0;
          ovf_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gessm_dot_accumulator.sv
// Directed bench: two instances (AW=40 and AW=33, LEN=4) share one stimulus stream.
module tb_gessm_dot_accumulator;

  localparam int unsigned PW  = 32;
  localparam int unsigned LEN = 4;
  localparam int unsigned CW  = $clog2(LEN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [PW-1:0] in_prod;
  logic          in_last;
  logic          out_ready;

  logic          a_in_ready, a_out_valid, a_out_ovf;
  logic [39:0]   a_out_sum;
  logic [CW-1:0] a_out_count;

  logic          b_in_ready, b_out_valid, b_out_ovf;
  logic [32:0]   b_out_sum;
  logic [CW-1:0] b_out_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  gessm_dot_accumulator #(
    .PW  (PW),
    .AW  (40),
    .LEN (LEN)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_sum   (a_out_sum),
    .out_count (a_out_count),
    .out_ovf   (a_out_ovf)
  );

  gessm_dot_accumulator #(
    .PW  (PW),
    .AW  (33),
    .LEN (LEN)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_sum   (b_out_sum),
    .out_count (b_out_count),
    .out_ovf   (b_out_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one beat for the following posedge.
  task automatic send_beat(input logic [PW-1:0] p, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic [39:0] sum, input int unsigned cnt, input logic ovf);
    check_eq({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    check_eq({tag, "_sum"},   64'(a_out_sum),   64'(sum));
    check_eq({tag, "_count"}, 64'(a_out_count), 64'(cnt));
    check_eq({tag, "_ovf"},   64'(a_out_ovf),   64'(ovf));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // 1: reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_in_ready",  64'(a_in_ready),  64'd1);
    check_eq("rst_out_sum",   64'(a_out_sum),   64'd0);
    check_eq("rst_out_count", 64'(a_out_count), 64'd0);
    check_eq("rst_out_ovf",   64'(a_out_ovf),   64'd0);
    check_eq("rst_b_valid",   64'(b_out_valid), 64'd0);

    // 2: full vector of 4 back-to-back beats
    for (int unsigned i = 1; i <= 4; i++) send_beat(PW'(i), 1'b0);
    check_a("full4", 40'd10, 4, 1'b0);
    check_eq("full4_in_ready", 64'(a_in_ready), 64'd0);
    take_result();
    check_eq("after_take_in_ready", 64'(a_in_ready), 64'd1);
    check_eq("after_take_valid",    64'(a_out_valid), 64'd0);

    // 3: early termination
    send_beat(PW'(100), 1'b0);
    send_beat(PW'(200), 1'b1);
    check_a("early2", 40'd300, 2, 1'b0);
    take_result();

    // 4: backpressure with a pending beat
    for (int unsigned i = 0; i < 4; i++) send_beat(PW'(1), 1'b0);
    check_a("bp_pre", 40'd4, 4, 1'b0);
    in_valid = 1'b1;
    in_prod  = PW'(50);
    in_last  = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("bp_hold_sum",   64'(a_out_sum),   64'd4);
      check_eq("bp_hold_count", 64'(a_out_count), 64'd4);
      check_eq("bp_hold_valid", 64'(a_out_valid), 64'd1);
      check_eq("bp_in_ready",   64'(a_in_ready),  64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release_in_ready", 64'(a_in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_a("bp_pending", 40'd50, 1, 1'b0);
    take_result();

    // in_last on the LEN-th beat: exactly one result
    for (int unsigned i = 1; i <= 4; i++) send_beat(PW'(i), (i == 4));
    check_a("last_at_len", 40'd10, 4, 1'b0);
    take_result();
    check_eq("no_double_0", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    check_eq("no_double_1", 64'(a_out_valid), 64'd0);

    // 5: saturation in the AW=33 instance, none in AW=40
    for (int unsigned i = 0; i < 4; i++) send_beat(32'hFFFF_FFFF, 1'b0);
    check_eq("sat_b_valid", 64'(b_out_valid), 64'd1);
    check_eq("sat_b_sum",   64'(b_out_sum),   64'h1_FFFF_FFFF);
    check_eq("sat_b_ovf",   64'(b_out_ovf),   64'd1);
    check_eq("sat_b_count", 64'(b_out_count), 64'd4);
    check_a("nosat_a", 40'h3_FFFF_FFFC, 4, 1'b0);
    take_result();
    for (int unsigned i = 0; i < 4; i++) send_beat(PW'(5), 1'b0);
    check_eq("post_sat_b_sum", 64'(b_out_sum), 64'd20);
    check_eq("post_sat_b_ovf", 64'(b_out_ovf), 64'd0);
    take_result();

    // 6: reset mid-vector discards partial sum
    send_beat(PW'(7), 1'b0);
    send_beat(PW'(9), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_valid",    64'(a_out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(a_in_ready),  64'd1);
    for (int unsigned i = 0; i < 4; i++) send_beat(PW'(1), 1'b0);
    check_a("midrst_vec", 40'd4, 4, 1'b0);
    take_result();

    // gapped input: 1 cycle on, 2 off
    for (int unsigned i = 0; i < 4; i++) begin
      send_beat(PW'(1), 1'b0);
      if (i < 3) begin
        repeat (2) @(negedge clk);
        check_eq("gap_no_valid", 64'(a_out_valid), 64'd0);
      end
    end
    check_a("gapped", 40'd4, 4, 1'b0);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
